// File: rtl/ctx_swap_pkg.sv
// Shared constants, state encoding and register-field helper for the context save/restore engine.
package ctx_swap_pkg;

    localparam int CTX_BITS  = 256;
    localparam int REG_BITS  = 32;
    localparam int NREGS_CTX = 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETTLE  = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_RESTORE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        SETTLE  = ST_SETTLE,
        CAPTURE = ST_CAPTURE,
        RESTORE = ST_RESTORE,
        DONE    = ST_DONE
    } state_t;

    // Reg 0 lives in the most significant word of a context image.
    function automatic logic [REG_BITS-1:0] ctx_reg(input logic [CTX_BITS-1:0] ctx,
                                                    input int unsigned idx);
        return ctx[REG_BITS*(NREGS_CTX-1-idx) +: REG_BITS];
    endfunction

endpackage

// File: rtl/ctx_swap_if.sv
// Scheduler and register-file bulk-port signals of the context engine; master = requester/regfile side.
interface ctx_swap_if
    import ctx_swap_pkg::*;
#(
    parameter int SLOTS  = 4,
    parameter int SLOT_W = 2
);
    logic                save_req;
    logic [SLOT_W-1:0]   save_slot;
    logic                restore_req;
    logic [SLOT_W-1:0]   restore_slot;
    logic                busy;
    logic                done;
    logic                err;
    logic [SLOTS-1:0]    slot_valid;
    logic                give_me;
    logic [CTX_BITS-1:0] the_regs;
    logic                writing_regs;
    logic [CTX_BITS-1:0] change_me;

    modport master (
        output save_req, save_slot, restore_req, restore_slot, the_regs,
        input  busy, done, err, slot_valid, give_me, writing_regs, change_me
    );

    modport slave (
        input  save_req, save_slot, restore_req, restore_slot, the_regs,
        output busy, done, err, slot_valid, give_me, writing_regs, change_me
    );
endinterface

// File: rtl/ctx_swap_store.sv
// Context slot storage: one write port, one combinational read port, per-slot valid flags.
module ctx_swap_store
    import ctx_swap_pkg::*;
#(
    parameter int SLOTS  = 4,
    parameter int SLOT_W = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [SLOT_W-1:0]   wr_idx,
    input  logic [CTX_BITS-1:0] wr_data,
    input  logic                clr_en,
    input  logic [SLOT_W-1:0]   clr_idx,
    input  logic [SLOT_W-1:0]   rd_idx,
    output logic [CTX_BITS-1:0] rd_data,
    output logic [SLOTS-1:0]    valid
);

    logic [CTX_BITS-1:0] mem [SLOTS];

    // Slot images survive reset; only the occupancy flags are cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else begin
            if (clr_en) begin
                valid[clr_idx] <= 1'b0;
            end
            if (wr_en) begin
                valid[wr_idx] <= 1'b1;
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/ctx_swap.sv
// Context save/restore FSM with hold and output registers.
// Optional build macro CTX_SWAP_EN: simultaneous save+restore performs an atomic swap.
module ctx_swap
    import ctx_swap_pkg::*;
#(
    parameter int SLOTS  = 4,
    parameter int SLOT_W = 2
) (
    input logic       clk,
    input logic       reset,
    ctx_swap_if.slave bus
);

    state_t              state;
    logic                swap_pend;
    logic [SLOT_W-1:0]   save_idx;
    logic [CTX_BITS-1:0] hold;
    logic [CTX_BITS-1:0] change_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;
    logic                give_r;
    logic                wr_r;

    logic [CTX_BITS-1:0] rd_data;
    logic [SLOTS-1:0]    slot_valid;
    logic                rs_ok;
    logic                take_save;
    logic                take_restore;
    logic                take_swap;
    logic                reject;

    assign rs_ok = slot_valid[bus.restore_slot];

    always_comb begin
        take_save    = 1'b0;
        take_restore = 1'b0;
        take_swap    = 1'b0;
        reject       = 1'b0;
        if (state == IDLE) begin
            if (bus.save_req && bus.restore_req) begin
`ifdef CTX_SWAP_EN
                if (rs_ok) begin
                    take_swap = 1'b1;
                end else begin
                    reject = 1'b1;
                end
`else
                take_save = 1'b1;
                reject    = 1'b1;
`endif
            end else if (bus.save_req) begin
                take_save = 1'b1;
            end else if (bus.restore_req) begin
                if (rs_ok) begin
                    take_restore = 1'b1;
                end else begin
                    reject = 1'b1;
                end
            end
        end
    end

    ctx_swap_store #(
        .SLOTS  (SLOTS),
        .SLOT_W (SLOT_W)
    ) u_store (
        .clk     (clk),
        .reset   (reset),
        .wr_en   ((state == CAPTURE) && !reset),
        .wr_idx  (save_idx),
        .wr_data (bus.the_regs),
        .clr_en  ((take_restore || take_swap) && !reset),
        .clr_idx (bus.restore_slot),
        .rd_idx  (bus.restore_slot),
        .rd_data (rd_data),
        .valid   (slot_valid)
    );

    // Data-only registers: slot index and swap image are meaningless outside an operation.
    always_ff @(posedge clk) begin
        if (take_save || take_swap) begin
            save_idx <= bus.save_slot;
        end
        if (take_swap) begin
            hold <= rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            swap_pend <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            give_r    <= 1'b0;
            wr_r      <= 1'b0;
            change_r  <= '0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            give_r <= 1'b0;
            wr_r   <= 1'b0;
            case (state)
                IDLE: begin
                    err_r <= reject;
                    if (take_save || take_swap) begin
                        state     <= SETTLE;
                        swap_pend <= take_swap;
                        busy_r    <= 1'b1;
                        give_r    <= 1'b1;
                    end else if (take_restore) begin
                        state     <= RESTORE;
                        swap_pend <= 1'b0;
                        busy_r    <= 1'b1;
                        wr_r      <= 1'b1;
                        change_r  <= rd_data;
                    end
                end
                // the_regs lags the dump request by a cycle, so capture waits one more.
                SETTLE: begin
                    state  <= CAPTURE;
                    give_r <= 1'b1;
                end
                CAPTURE: begin
                    if (swap_pend) begin
                        state    <= RESTORE;
                        wr_r     <= 1'b1;
                        change_r <= hold;
                    end else begin
                        state  <= DONE;
                        done_r <= 1'b1;
                    end
                end
                RESTORE: begin
                    state  <= DONE;
                    done_r <= 1'b1;
                end
                DONE: begin
                    state     <= IDLE;
                    swap_pend <= 1'b0;
                    busy_r    <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.err          = err_r;
    assign bus.slot_valid   = slot_valid;
    assign bus.give_me      = give_r;
    assign bus.writing_regs = wr_r;
    assign bus.change_me    = change_r;

endmodule
